// File: rtl/logic_unit_arb_if.sv
// ============================================================================
// logic_unit_arb_if : requester/arbiter bundle for the shared logic unit
// Rev 1.0
// ============================================================================
`default_nettype none

interface logic_unit_arb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2
);
  logic                  REQ0;
  logic [OP_WIDTH-1:0]   OP0;
  logic [DATA_WIDTH-1:0] A0;
  logic [DATA_WIDTH-1:0] B0;
  logic                  REQ1;
  logic [OP_WIDTH-1:0]   OP1;
  logic [DATA_WIDTH-1:0] A1;
  logic [DATA_WIDTH-1:0] B1;
  logic                  GNT0;
  logic                  GNT1;
  logic                  DONE0;
  logic                  DONE1;
  logic [DATA_WIDTH-1:0] Y;
  logic                  BUSY;

  modport master (
    output REQ0, OP0, A0, B0, REQ1, OP1, A1, B1,
    input  GNT0, GNT1, DONE0, DONE1, Y, BUSY
  );

  modport slave (
    input  REQ0, OP0, A0, B0, REQ1, OP1, A1, B1,
    output GNT0, GNT1, DONE0, DONE1, Y, BUSY
  );
endinterface

`default_nettype wire

// File: rtl/logic_unit_arb.sv
// ============================================================================
// logic_unit_arb : two-requester round-robin arbiter for a shared AND/OR/NOR/INV unit
// Rev 1.0
// ============================================================================
`default_nettype none

module logic_unit_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  logic_unit_arb_if.slave  bus
);

  localparam logic [OP_WIDTH-1:0] c_OP_AND = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] c_OP_OR  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] c_OP_NOR = OP_WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic                  r_pri;
  logic                  r_sel;
  logic [OP_WIDTH-1:0]   r_op;
  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_y;
  logic                  r_gnt0;
  logic                  r_gnt1;
  logic                  r_done0;
  logic                  r_done1;
  logic                  r_busy;

  logic                  w_any_req;
  logic                  w_pick;
  logic [DATA_WIDTH-1:0] w_result;

  // A lone requester wins outright; the pointer only breaks ties.
  assign w_any_req = bus.REQ0 | bus.REQ1;
  assign w_pick    = (bus.REQ0 & bus.REQ1) ? r_pri : bus.REQ1;

  always_comb begin
    w_result = '0;
    case (r_op)
      c_OP_AND: w_result = r_a & r_b;
      c_OP_OR:  w_result = r_a | r_b;
      c_OP_NOR: w_result = ~(r_a | r_b);
      default:  w_result = ~r_a;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= IDLE;
      r_pri   <= 1'b0;
      r_sel   <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_y     <= '0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_pick;
            r_op    <= w_pick ? bus.OP1 : bus.OP0;
            r_a     <= w_pick ? bus.A1  : bus.A0;
            r_b     <= w_pick ? bus.B1  : bus.B0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_busy  <= 1'b1;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_y     <= w_result;
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= ~r_sel;
          r_done1 <= r_sel;
          r_state <= RESP;
        end
        RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_pri   <= ~r_sel;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_gnt0  <= 1'b0;
          r_gnt1  <= 1'b0;
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.GNT0  = r_gnt0;
  assign bus.GNT1  = r_gnt1;
  assign bus.DONE0 = r_done0;
  assign bus.DONE1 = r_done1;
  assign bus.Y     = r_y;
  assign bus.BUSY  = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_arb.sv
// ============================================================================
// tb_logic_unit_arb : directed self-checking bench for logic_unit_arb
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_logic_unit_arb;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  logic_unit_arb_if #(.DATA_WIDTH(32), .OP_WIDTH(2)) bus ();

  logic_unit_arb #(.DATA_WIDTH(32), .OP_WIDTH(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.REQ0 = 1'b0; bus.OP0 = 2'b00; bus.A0 = '0; bus.B0 = '0;
    bus.REQ1 = 1'b0; bus.OP1 = 2'b00; bus.A1 = '0; bus.B1 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.BUSY} !== 5'b0 || bus.Y !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: flags=%b Y=%h, required flags=00000 Y=00000000",
               {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.BUSY}, bus.Y);
    end
    // start an op, then reset while it is in EXEC
    bus.REQ0 = 1'b1; bus.OP0 = 2'b01; bus.A0 = 32'hF0F0F0F0; bus.B0 = 32'hFF00FF00;
    tick();
    RST = 1'b0;
    #1;
    checks++;
    if ({bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.BUSY} !== 5'b0 || bus.Y !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_exec: flags=%b Y=%h, required flags=00000 Y=00000000",
               {bus.GNT0, bus.GNT1, bus.DONE0, bus.DONE1, bus.BUSY}, bus.Y);
    end
    bus.REQ0 = 1'b0;
    tick();
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.DONE0 !== 1'b0 || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done: cycle %0d DONE0=%b BUSY=%b, required 0 0", i, bus.DONE0, bus.BUSY);
      end
    end
    bus.REQ0 = 1'b1;
    bus.REQ1 = 1'b1;
    tick();
    checks++;
    if (bus.GNT0 !== 1'b1 || bus.GNT1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_pri: GNT0=%b GNT1=%b, required 1 0", bus.GNT0, bus.GNT1);
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_opcodes();
    logic [31:0] exp_y [4];
    exp_y[0] = 32'hF000F000;
    exp_y[1] = 32'hFFF0FFF0;
    exp_y[2] = 32'h000F000F;
    exp_y[3] = 32'h0F0F0F0F;
    apply_reset();
    for (int op = 0; op < 4; op++) begin
      bus.REQ0 = 1'b1; bus.OP0 = op[1:0]; bus.A0 = 32'hF0F0F0F0; bus.B0 = 32'hFF00FF00;
      tick();
      checks++;
      if (bus.GNT0 !== 1'b1 || bus.DONE0 !== 1'b0 || bus.BUSY !== 1'b1) begin
        errors++;
        $display("FAIL op%0d_grant: GNT0=%b DONE0=%b BUSY=%b, required 1 0 1", op, bus.GNT0, bus.DONE0, bus.BUSY);
      end
      tick();
      checks++;
      if (bus.DONE0 !== 1'b1 || bus.GNT0 !== 1'b0 || bus.Y !== exp_y[op]) begin
        errors++;
        $display("FAIL op%0d_done: DONE0=%b GNT0=%b Y=%h, required 1 0 %h", op, bus.DONE0, bus.GNT0, bus.Y, exp_y[op]);
      end
      bus.REQ0 = 1'b0;
      tick();
      checks++;
      if (bus.DONE0 !== 1'b0 || bus.BUSY !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_resp: DONE0=%b BUSY=%b, required 0 0", op, bus.DONE0, bus.BUSY);
      end
    end
  endtask

  task automatic test_operand_stability();
    apply_reset();
    bus.REQ0 = 1'b1; bus.OP0 = 2'b00; bus.A0 = 32'hF0F0F0F0; bus.B0 = 32'hFF00FF00;
    tick();
    bus.A0 = 32'hFFFFFFFF;
    tick();
    checks++;
    if (bus.DONE0 !== 1'b1 || bus.Y !== 32'hF000F000) begin
      errors++;
      $display("FAIL operand_latch: DONE0=%b Y=%h, required 1 f000f000", bus.DONE0, bus.Y);
    end
    bus.REQ0 = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    logic exp_k;
    apply_reset();
    bus.REQ0 = 1'b1; bus.OP0 = 2'b01; bus.A0 = 32'hF0F0F0F0; bus.B0 = 32'hFF00FF00;
    bus.REQ1 = 1'b1; bus.OP1 = 2'b11; bus.A1 = 32'h12345678; bus.B1 = 32'h0;
    for (int i = 0; i < 4; i++) begin
      exp_k = i[0];
      tick();
      checks++;
      if (bus.GNT0 !== ~exp_k || bus.GNT1 !== exp_k) begin
        errors++;
        $display("FAIL contend%0d_grant: GNT0=%b GNT1=%b, required %b %b", i, bus.GNT0, bus.GNT1, ~exp_k, exp_k);
      end
      tick();
      checks++;
      if (bus.DONE0 !== ~exp_k || bus.DONE1 !== exp_k ||
          bus.Y !== (exp_k ? 32'hEDCBA987 : 32'hFFF0FFF0)) begin
        errors++;
        $display("FAIL contend%0d_done: DONE0=%b DONE1=%b Y=%h, required %b %b %h", i,
                 bus.DONE0, bus.DONE1, bus.Y, ~exp_k, exp_k, exp_k ? 32'hEDCBA987 : 32'hFFF0FFF0);
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_late_arrival();
    apply_reset();
    bus.REQ0 = 1'b1; bus.OP0 = 2'b00; bus.A0 = 32'hF0F0F0F0; bus.B0 = 32'hFF00FF00;
    tick();
    bus.REQ1 = 1'b1; bus.OP1 = 2'b01; bus.A1 = 32'h0000FFFF; bus.B1 = 32'h00FF0000;
    tick();
    bus.REQ0 = 1'b0;
    tick();
    checks++;
    if (bus.GNT1 !== 1'b0 || bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL late_wait: GNT1=%b BUSY=%b, required 0 0", bus.GNT1, bus.BUSY);
    end
    tick();
    checks++;
    if (bus.GNT1 !== 1'b1 || bus.GNT0 !== 1'b0) begin
      errors++;
      $display("FAIL late_grant: GNT0=%b GNT1=%b, required 0 1", bus.GNT0, bus.GNT1);
    end
    tick();
    checks++;
    if (bus.DONE1 !== 1'b1 || bus.Y !== 32'h00FFFFFF) begin
      errors++;
      $display("FAIL late_done: DONE1=%b Y=%h, required 1 00ffffff", bus.DONE1, bus.Y);
    end
    bus.REQ1 = 1'b0;
    tick();
  endtask

  task automatic test_lone_repeat();
    apply_reset();
    bus.REQ1 = 1'b1; bus.OP1 = 2'b00; bus.A1 = 32'h0000FFFF; bus.B1 = 32'h00FF00FF;
    tick();
    checks++;
    if (bus.GNT1 !== 1'b1 || bus.GNT0 !== 1'b0) begin
      errors++;
      $display("FAIL lone1_grant: GNT0=%b GNT1=%b, required 0 1", bus.GNT0, bus.GNT1);
    end
    tick();
    checks++;
    if (bus.DONE1 !== 1'b1 || bus.Y !== 32'h000000FF) begin
      errors++;
      $display("FAIL lone1_done: DONE1=%b Y=%h, required 1 000000ff", bus.DONE1, bus.Y);
    end
    bus.OP1 = 2'b10;
    tick();
    tick();
    checks++;
    if (bus.GNT1 !== 1'b1 || bus.GNT0 !== 1'b0) begin
      errors++;
      $display("FAIL lone2_grant: GNT0=%b GNT1=%b, required 0 1", bus.GNT0, bus.GNT1);
    end
    tick();
    checks++;
    if (bus.DONE1 !== 1'b1 || bus.DONE0 !== 1'b0 || bus.Y !== 32'hFF000000) begin
      errors++;
      $display("FAIL lone2_done: DONE0=%b DONE1=%b Y=%h, required 0 1 ff000000", bus.DONE0, bus.DONE1, bus.Y);
    end
    bus.REQ1 = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST    = 1'b0;
    idle_inputs();
    test_reset();
    test_opcodes();
    test_operand_stability();
    test_contention();
    test_late_arrival();
    test_lone_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
